// File: rtl/ft245_pkg.sv
// Shared types and defaults for the FT2232H synchronous 245 transmit path.
package ft245_pkg;

    localparam int FT_DSIZE        = 8;
    localparam int FT_FLUSH_CYCLES = 1024;
    localparam int FT_CNT_W        = 32;
    localparam int FT_IDLE_W       = 16;

    typedef logic [FT_DSIZE-1:0] ft_byte_t;
    typedef logic [1:0]          buf_cnt_t;

    localparam buf_cnt_t BUF_EMPTY = 2'd0;
    localparam buf_cnt_t BUF_ONE   = 2'd1;
    localparam buf_cnt_t BUF_FULL  = 2'd2;

endpackage

// File: rtl/ft_skid_buf.sv
// Two-entry head/skid buffer between the fall-through FIFO and the FTDI bus.
module ft_skid_buf
    import ft245_pkg::*;
#(
    parameter int DSIZE = FT_DSIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [DSIZE-1:0] head,
    output buf_cnt_t         cnt,
    output buf_cnt_t         cnt_nxt
);

    logic [DSIZE-1:0] skid;
    logic [DSIZE-1:0] head_nxt;
    logic [DSIZE-1:0] skid_nxt;

    // Head only changes when something remains to present, so the bus holds
    // its last byte once the buffer drains.
    always_comb begin
        head_nxt = head;
        skid_nxt = skid;
        cnt_nxt  = cnt;
        unique case ({push, pop})
            2'b10: begin
                if (cnt == BUF_EMPTY) begin
                    head_nxt = push_data;
                end else begin
                    skid_nxt = push_data;
                end
                cnt_nxt = cnt + 2'd1;
            end
            2'b01: begin
                if (cnt == BUF_FULL) begin
                    head_nxt = skid;
                end
                cnt_nxt = cnt - 2'd1;
            end
            2'b11: begin
                if (cnt == BUF_FULL) begin
                    head_nxt = skid;
                    skid_nxt = push_data;
                end else begin
                    head_nxt = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
            cnt  <= BUF_EMPTY;
        end else begin
            head <= head_nxt;
            skid <= skid_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ft245_sync_tx.sv
// FT2232H sync-245 transmit drain: FIFO pop, WR#/TXE# handshake, SIWU# flush.
module ft245_sync_tx
    import ft245_pkg::*;
#(
    parameter int DSIZE        = FT_DSIZE,
    parameter int FLUSH_CYCLES = FT_FLUSH_CYCLES,
    parameter int CNT_W        = FT_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             fifo_rd_en_o,
    input  logic [DSIZE-1:0] fifo_rd_data_i,
    input  logic             fifo_rd_empty_i,
    input  logic             ft_txe_n_i,
    output logic             ft_wr_n_o,
    output logic [DSIZE-1:0] ft_data_o,
    output logic             ft_data_oe_o,
    output logic             ft_siwu_n_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] tx_count_o
);

    localparam logic [FT_IDLE_W-1:0] IDLE_LAST = FT_IDLE_W'(FLUSH_CYCLES - 1);

    logic                 accept;
    logic                 pop;
    logic                 idle_run;
    logic                 flush_fire;
    logic                 armed;
    logic [FT_IDLE_W-1:0] idle_cnt;
    buf_cnt_t             cnt;
    buf_cnt_t             cnt_nxt;
    logic [DSIZE-1:0]     head;

    // The FTDI latches the bus at any edge where WR# and TXE# are both low.
    assign accept = ~ft_wr_n_o & ~ft_txe_n_i;
    assign pop    = ~fifo_rd_empty_i & ~reset_i &
                    ((cnt != BUF_FULL) | accept);

    assign fifo_rd_en_o = pop;
    assign ft_data_o    = head;

    ft_skid_buf #(
        .DSIZE(DSIZE)
    ) u_buf (
        .clk      (clk_i),
        .reset    (reset_i),
        .push     (pop),
        .push_data(fifo_rd_data_i),
        .pop      (accept),
        .head     (head),
        .cnt      (cnt),
        .cnt_nxt  (cnt_nxt)
    );

    // Idle time only accrues once the pipe is fully drained.
    always_comb begin
        idle_run   = armed & (cnt == BUF_EMPTY) & fifo_rd_empty_i;
        flush_fire = idle_run & (idle_cnt == IDLE_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ft_wr_n_o    <= 1'b1;
            ft_siwu_n_o  <= 1'b1;
            ft_data_oe_o <= 1'b0;
            busy_o       <= 1'b0;
            tx_count_o   <= '0;
            idle_cnt     <= '0;
            armed        <= 1'b0;
        end else begin
            ft_data_oe_o <= 1'b1;
            ft_wr_n_o    <= ~((cnt_nxt != BUF_EMPTY) & ~ft_txe_n_i);
            busy_o       <= (cnt_nxt != BUF_EMPTY);
            ft_siwu_n_o  <= ~flush_fire;
            if (accept) begin
                tx_count_o <= tx_count_o + CNT_W'(1);
            end
            if (accept) begin
                armed    <= 1'b1;
                idle_cnt <= '0;
            end else if (pop) begin
                idle_cnt <= '0;
            end else if (flush_fire) begin
                armed    <= 1'b0;
                idle_cnt <= '0;
            end else if (idle_run) begin
                idle_cnt <= idle_cnt + FT_IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Directed and randomized bench for ft245_sync_tx against a FIFO/FTDI model.
module tb_ft245_sync_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        txe_n = 1'b1;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic        wr_n;
    logic [7:0]  bus;
    logic        oe;
    logic        siwu_n;
    logic        busy;
    logic [31:0] tx_count;

    logic [7:0]  mem [0:2047];
    logic [15:0] wr_ptr = '0;
    logic [15:0] rd_ptr = '0;
    logic [7:0]  rx [$];

    int cyc = 0;
    int last_acc = 0;
    int siwu_lows = 0;
    int siwu_cyc = 0;
    int overlap = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data  = mem[rd_ptr[10:0]];
    assign rd_empty = (rd_ptr == wr_ptr);

    ft245_sync_tx #(
        .DSIZE(8),
        .FLUSH_CYCLES(8),
        .CNT_W(32)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .fifo_rd_en_o   (rd_en),
        .fifo_rd_data_i (rd_data),
        .fifo_rd_empty_i(rd_empty),
        .ft_txe_n_i     (txe_n),
        .ft_wr_n_o      (wr_n),
        .ft_data_o      (bus),
        .ft_data_oe_o   (oe),
        .ft_siwu_n_o    (siwu_n),
        .busy_o         (busy),
        .tx_count_o     (tx_count)
    );

    // FIFO read side and FTDI receiver model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_ptr <= rd_ptr + 16'd1;
        if (!wr_n && !txe_n) begin
            rx.push_back(bus);
            last_acc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!siwu_n) begin
            siwu_lows <= siwu_lows + 1;
            siwu_cyc  <= cyc;
            if (!wr_n) overlap <= overlap + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[10:0]] = b;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_count(input string tag, input int n, input int budget);
        int k = 0;
        while (tx_count != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, tx_count, n);
    endtask

    initial begin
        int base;
        int start;
        int guard;
        int sent;
        int k;
        int sbase;
        int popped;
        int rem_start;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_siwu_n", siwu_n, 1);
        chk("rst_oe", oe, 0);
        chk("rst_data", bus, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", tx_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("oe_after_rst", oe, 1);

        // Empty FIFO with TXE# low: nothing happens, then a single byte.
        txe_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("empty_wr_n", wr_n, 1);
            chk("empty_rd_en", rd_en, 0);
        end
        base = rx.size();
        push(8'hA5);
        repeat (6) @(negedge clk);
        chk("single_n", rx.size() - base, 1);
        if (rx.size() > base) chk("single_data", rx[base], 8'hA5);
        chk("single_count", tx_count, 1);

        // Full-rate burst of 0x01..0x10.
        do_reset();
        base = rx.size();
        for (int i = 1; i <= 16; i++) push(8'(i));
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            chk("burst_wr_n", wr_n, (j <= 16) ? 1'b0 : 1'b1);
            if (j <= 16) chk("burst_bus", bus, j);
        end
        chk("burst_count", tx_count, 16);
        chk("burst_n", rx.size() - base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < rx.size()) chk("burst_rx", rx[base+i], i + 1);

        // TXE# stall on 0x05.
        do_reset();
        base = rx.size();
        for (int i = 1; i <= 16; i++) push(8'(i));
        guard = 0;
        while (!(wr_n == 1'b0 && bus == 8'h05) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("stall_found", guard < 40, 1);
        txe_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", bus, 8'h05);
        end
        txe_n = 1'b0;
        wait_count("stall_count", 16, 60);
        repeat (3) @(negedge clk);
        chk("stall_n", rx.size() - base, 16);
        for (int i = 0; i < 16; i++)
            if (base + i < rx.size()) chk("stall_rx", rx[base+i], i + 1);

        // SIWU# flush after 3 bytes.
        do_reset();
        sbase = siwu_lows;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_count("flush_count", 3, 30);
        repeat (120) @(negedge clk);
        chk("flush_pulses", siwu_lows - sbase, 1);
        chk("flush_delay", siwu_cyc - last_acc, 8);

        // Reset while both buffer entries are full.
        do_reset();
        base = rx.size();
        start = rd_ptr;
        txe_n = 1'b1;
        for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
        txe_n = 1'b0;
        repeat (5) @(negedge clk);
        txe_n = 1'b1;
        repeat (3) @(negedge clk);
        popped = int'(rd_ptr) - start;
        chk("mid_cnt2", popped - (rx.size() - base), 2);
        chk("mid_busy", busy, 1);
        rem_start = rd_ptr;
        reset = 1'b1;
        txe_n = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_wr_n", wr_n, 1);
        chk("mid_oe", oe, 0);
        chk("mid_count", tx_count, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_no_pop", rd_ptr, rem_start);
        base = rx.size();
        @(negedge clk);
        chk("mid_oe1", oe, 1);
        wait_count("mid_drain", int'(wr_ptr) - rem_start, 60);
        chk("mid_n", rx.size() - base, int'(wr_ptr) - rem_start);
        for (int i = 0; i < int'(wr_ptr) - rem_start; i++)
            if (base + i < rx.size())
                chk("mid_rx", rx[base+i], mem[11'(rem_start + i)]);

        // Random TXE# and random FIFO arrivals over 1000 bytes.
        do_reset();
        base = rx.size();
        start = wr_ptr;
        sent = 0;
        k = 0;
        while ((sent < 1000 || tx_count != 1000) && k < 20000) begin
            @(negedge clk);
            txe_n = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                push(8'($urandom_range(0, 255)));
                sent++;
            end
            k++;
        end
        txe_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rand_count", tx_count, 1000);
        chk("rand_n", rx.size() - base, 1000);
        chk("rand_drained", rd_ptr, wr_ptr);
        for (int i = 0; i < 1000; i++)
            if (base + i < rx.size())
                chk("rand_rx", rx[base+i], mem[11'(start + i)]);

        chk("siwu_wr_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
